// File: rtl/dsp_muladd_acc_pipe.sv
// dsp_muladd_acc_pipe -- pipelined signed a*b+c / a*b+y multiply-accumulate, rev 1.0
// Define DSP_MULADD_SATURATE_EN to clamp results to OUT_WIDTH instead of wrapping.
`default_nettype none

module dsp_muladd_acc_pipe #(
  parameter int WIDTH      = 8,
  parameter int OUT_WIDTH  = 8,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  input  logic signed [WIDTH-1:0]     c,
  input  logic                        mode,
  input  logic                        clr,
  output logic signed [OUT_WIDTH-1:0] y,
  output logic                        out_valid
);

  localparam int PROD_W = 2 * WIDTH;
  // One guard bit beyond 2*WIDTH+1 so a wide accumulator plus a maximal product cannot overflow before clamping.
  localparam int SUM_W  = 2 * WIDTH + 2;

  localparam logic signed [SUM_W-1:0] c_sat_max = {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] c_sat_min = ~c_sat_max;

  logic                     w_v;
  logic                     w_mode;
  logic signed [WIDTH-1:0]  w_c;
  logic signed [PROD_W-1:0] w_prod;

  generate
    if (PIPE_DEPTH == 1) begin : g_direct
      assign w_v    = in_valid;
      assign w_mode = mode;
      assign w_c    = c;
      assign w_prod = PROD_W'(a) * PROD_W'(b);
    end else begin : g_piped
      logic                     r_v1;
      logic                     r_mode1;
      logic signed [WIDTH-1:0]  r_a1;
      logic signed [WIDTH-1:0]  r_b1;
      logic signed [WIDTH-1:0]  r_c1;
      logic signed [PROD_W-1:0] w_prod1;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_v1    <= 1'b0;
          r_mode1 <= 1'b0;
          r_a1    <= '0;
          r_b1    <= '0;
          r_c1    <= '0;
        end else if (en) begin
          r_v1    <= in_valid;
          r_mode1 <= mode;
          r_a1    <= a;
          r_b1    <= b;
          r_c1    <= c;
        end
      end

      assign w_prod1 = PROD_W'(r_a1) * PROD_W'(r_b1);

      if (PIPE_DEPTH == 2) begin : g_short
        assign w_v    = r_v1;
        assign w_mode = r_mode1;
        assign w_c    = r_c1;
        assign w_prod = w_prod1;
      end else begin : g_deep
        localparam int N = PIPE_DEPTH - 2;
        logic                     r_v    [N];
        logic                     r_mode [N];
        logic signed [WIDTH-1:0]  r_c    [N];
        logic signed [PROD_W-1:0] r_prod [N];

        always_ff @(posedge clock or negedge reset) begin
          if (!reset) begin
            for (int i = 0; i < N; i++) begin
              r_v[i]    <= 1'b0;
              r_mode[i] <= 1'b0;
              r_c[i]    <= '0;
              r_prod[i] <= '0;
            end
          end else if (en) begin
            r_v[0]    <= r_v1;
            r_mode[0] <= r_mode1;
            r_c[0]    <= r_c1;
            r_prod[0] <= w_prod1;
            for (int i = 1; i < N; i++) begin
              r_v[i]    <= r_v[i-1];
              r_mode[i] <= r_mode[i-1];
              r_c[i]    <= r_c[i-1];
              r_prod[i] <= r_prod[i-1];
            end
          end
        end

        assign w_v    = r_v[N-1];
        assign w_mode = r_mode[N-1];
        assign w_c    = r_c[N-1];
        assign w_prod = r_prod[N-1];
      end
    end
  endgenerate

  logic signed [SUM_W-1:0]     w_acc;
  logic signed [SUM_W-1:0]     w_sum;
  logic signed [OUT_WIDTH-1:0] w_res;

  // clr only zeroes the accumulator operand; a mode-0 addend is never affected.
  assign w_acc = w_mode ? (clr ? '0 : SUM_W'(y)) : SUM_W'(w_c);
  assign w_sum = SUM_W'(w_prod) + w_acc;

`ifdef DSP_MULADD_SATURATE_EN
  always_comb begin
    w_res = w_sum[OUT_WIDTH-1:0];
    if (w_sum > c_sat_max)      w_res = c_sat_max[OUT_WIDTH-1:0];
    else if (w_sum < c_sat_min) w_res = c_sat_min[OUT_WIDTH-1:0];
  end
`else
  logic w_unused_sum_hi;
  assign w_unused_sum_hi = ^{w_sum[SUM_W-1:OUT_WIDTH], c_sat_max, c_sat_min};
  assign w_res = w_sum[OUT_WIDTH-1:0];
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      y         <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (w_v) begin
        y         <= w_res;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
        if (clr) y <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dsp_muladd_acc_pipe.sv
// tb_dsp_muladd_acc_pipe -- self-checking bench for dsp_muladd_acc_pipe, rev 1.0
// Honours DSP_MULADD_SATURATE_EN for the expected reduction of results.
`default_nettype none

module tb_dsp_muladd_acc_pipe;
  localparam int W  = 8;
  localparam int OW = 8;
  localparam int D  = 3;
`ifdef DSP_MULADD_SATURATE_EN
  localparam int EXP_BIG = 127;
`else
  localparam int EXP_BIG = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b0;
  logic in_valid = 1'b0;
  logic mode = 1'b0;
  logic clr = 1'b0;
  logic signed [W-1:0]  a = '0;
  logic signed [W-1:0]  b = '0;
  logic signed [W-1:0]  c = '0;
  logic signed [OW-1:0] y;
  logic                 out_valid;

  always #5 clock = ~clock;

  dsp_muladd_acc_pipe #(.WIDTH(W), .OUT_WIDTH(OW), .PIPE_DEPTH(D)) dut (
    .clock(clock), .reset(reset), .en(en), .in_valid(in_valid),
    .a(a), .b(b), .c(c), .mode(mode), .clr(clr),
    .y(y), .out_valid(out_valid)
  );

  typedef struct { bit v; bit m; int a; int b; int c; } op_t;
  op_t q[$];
  int  m_y;
  bit  m_ov;
  int  n_checks = 0;
  int  n_fail = 0;

  function automatic int fit(longint s);
    longint hi, m, r;
    hi = (longint'(1) <<< (OW-1)) - 1;
    m  = longint'(1) <<< OW;
`ifdef DSP_MULADD_SATURATE_EN
    r = m;
    if (s > hi) return int'(hi);
    if (s < -(hi + 1)) return int'(-(hi + 1));
    return int'(s);
`else
    r = s % m;
    if (r < 0) r += m;
    if (r > hi) r -= m;
    return int'(r);
`endif
  endfunction

  // Reference: every enabled edge captures an operand set; the set captured D edges ago takes effect.
  task automatic tick();
    op_t o;
    longint acc;
    if (reset && en) begin
      o.v = in_valid; o.m = mode; o.a = int'(a); o.b = int'(b); o.c = int'(c);
      q.push_back(o);
      if (q.size() == D) begin
        o = q.pop_front();
        if (o.v) begin
          acc  = o.m ? (clr ? 0 : m_y) : o.c;
          m_y  = fit(longint'(o.a) * o.b + acc);
          m_ov = 1'b1;
        end else begin
          if (clr) m_y = 0;
          m_ov = 1'b0;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic rand_inputs(bit allow_clr);
    in_valid = ($urandom_range(9, 0) < 7);
    mode     = $urandom_range(1, 0) == 1;
    clr      = allow_clr && ($urandom_range(4, 0) == 0);
    a = W'($urandom); b = W'($urandom); c = W'($urandom);
  endtask

  task automatic test_reset();
    en = 1'b1;
    #3;
    n_checks++;
    if (y !== 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_initial y=%0d ov=%b expected y=0 ov=0", y, out_valid);
    end
    in_valid = 1'b1; a = 8'sd9; b = 8'sd9;
    repeat (2) tick();
    n_checks++;
    if (y !== 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_held y=%0d ov=%b expected y=0 ov=0", y, out_valid);
    end
    in_valid = 1'b0;
    q.delete(); m_y = 0; m_ov = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_mode0();
    in_valid = 1'b1; mode = 1'b0; clr = 1'b0; a = 8'sd127; b = 8'sd1; c = -8'sd50;
    for (int k = 1; k <= 5; k++) begin
      tick();
      n_checks++;
      if (out_valid !== (k >= 3) || y !== ((k >= 3) ? 8'sd77 : 8'sd0)) begin
        n_fail++; $display("FAIL mode0_edge%0d y=%0d ov=%b expected y=%0d ov=%b", k, y, out_valid, (k >= 3) ? 77 : 0, (k >= 3));
      end
    end
  endtask

  task automatic test_wrap();
    a = 8'sd127; b = 8'sd127; c = 8'sd0;
    for (int k = 1; k <= 3; k++) tick();
    n_checks++;
    if (y !== OW'(EXP_BIG) || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_or_sat y=%0d ov=%b expected y=%0d ov=1", y, out_valid, EXP_BIG);
    end
  endtask

  task automatic test_accum();
    in_valid = 1'b0;
    repeat (3) tick();
    clr = 1'b1;
    tick();
    n_checks++;
    if (y !== 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_idle y=%0d ov=%b expected y=0 ov=0", y, out_valid);
    end
    clr = 1'b0; mode = 1'b1; a = 8'sd3; b = -8'sd2; in_valid = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      if (k == 5) in_valid = 1'b0;
      tick();
      n_checks++;
      if (y !== OW'((k >= 3) ? -6 * (k - 2) : 0) || out_valid !== (k >= 3)) begin
        n_fail++; $display("FAIL accum_edge%0d y=%0d ov=%b expected y=%0d ov=%b", k, y, out_valid, (k >= 3) ? -6 * (k - 2) : 0, (k >= 3));
      end
    end
  endtask

  task automatic test_enable();
    logic signed [OW-1:0] sy;
    logic sov;
    for (int k = 0; k < 4; k++) begin
      rand_inputs(1'b0); in_valid = 1'b1;
      tick();
    end
    sy = y; sov = out_valid;
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_inputs(1'b1);
      tick();
      n_checks++;
      if (y !== sy || out_valid !== sov) begin
        n_fail++; $display("FAIL enable_freeze%0d y=%0d ov=%b expected y=%0d ov=%b", k, y, out_valid, sy, sov);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      rand_inputs(1'b0);
      tick();
      n_checks++;
      if (y !== OW'(m_y) || out_valid !== m_ov) begin
        n_fail++; $display("FAIL enable_resume%0d y=%0d ov=%b expected y=%0d ov=%b", k, y, out_valid, m_y, m_ov);
      end
    end
  endtask

  task automatic test_bubble();
    in_valid = 1'b0; clr = 1'b0;
    repeat (3) tick();
    mode = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_valid = (k == 1 || k == 3);
      if (k == 1) begin a = 8'sd5;  b = 8'sd6; c = -8'sd7; end
      if (k == 3) begin a = -8'sd4; b = 8'sd9; c = 8'sd10; end
      tick();
      if (k >= 3) begin
        n_checks++;
        if (out_valid !== (k != 4) || y !== ((k == 5) ? -8'sd26 : 8'sd23)) begin
          n_fail++; $display("FAIL bubble_edge%0d y=%0d ov=%b expected y=%0d ov=%b", k, y, out_valid, (k == 5) ? -26 : 23, (k != 4));
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    in_valid = 1'b1; mode = 1'b0; a = 8'sd2; b = 8'sd2; c = 8'sd2;
    repeat (2) tick();
    #2 reset = 1'b0;
    q.delete(); m_y = 0; m_ov = 1'b0;
    #1;
    n_checks++;
    if (y !== 0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_async y=%0d ov=%b expected y=0 ov=0", y, out_valid);
    end
    in_valid = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (y !== 0 || out_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_no_ghost%0d y=%0d ov=%b expected y=0 ov=0", k, y, out_valid);
      end
    end
  endtask

  task automatic test_clr_corner();
    in_valid = 1'b1; clr = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k == 1) begin mode = 1'b0; a = 8'sd10; b = 8'sd10; c = 8'sd0; end
      if (k == 2) begin mode = 1'b1; a = 8'sd2;  b = 8'sd3;  c = 8'sd50; end
      if (k == 3) begin mode = 1'b0; a = 8'sd4;  b = 8'sd5;  c = 8'sd1; end
      if (k == 4) in_valid = 1'b0;
      clr = (k >= 4);
      tick();
      if (k >= 3) begin
        n_checks++;
        if (y !== ((k == 3) ? 8'sd100 : (k == 4) ? 8'sd6 : 8'sd21) || out_valid !== 1'b1) begin
          n_fail++; $display("FAIL clr_corner_edge%0d y=%0d ov=%b expected y=%0d ov=1", k, y, out_valid, (k == 3) ? 100 : (k == 4) ? 6 : 21);
        end
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rand_inputs(1'b1);
      en = ($urandom_range(9, 0) != 0);
      tick();
      n_checks++;
      if (y !== OW'(m_y) || out_valid !== m_ov) begin
        n_fail++; $display("FAIL random%0d y=%0d ov=%b expected y=%0d ov=%b", k, y, out_valid, m_y, m_ov);
      end
    end
    en = 1'b1;
  endtask

  initial begin
    m_y = 0; m_ov = 1'b0;
    test_reset();
    test_mode0();
    test_wrap();
    test_accum();
    test_enable();
    test_bubble();
    test_reset_midflight();
    test_clr_corner();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/dsp_muladd_acc_pipe.md
DSP_MULADD_ACC_PIPE -- requirements
Module: dsp_muladd_acc_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, signed operand width of a, b and c (WIDTH >= 2).
REQ-002 SHALL have parameter OUT_WIDTH, default 8, signed result width of y (WIDTH <= OUT_WIDTH <= 2*WIDTH+1).
REQ-003 SHALL have parameter PIPE_DEPTH, default 3, input-to-output latency in enabled cycles (PIPE_DEPTH >= 1).
REQ-004 SHALL have port clock, input, 1 bit: single clock; all registers on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: global clock enable for every register.
REQ-007 SHALL have port in_valid, input, 1 bit: a, b, c and mode are valid this cycle.
REQ-008 SHALL have port a, input, WIDTH bits: signed multiplicand.
REQ-009 SHALL have port b, input, WIDTH bits: signed multiplier.
REQ-010 SHALL have port c, input, WIDTH bits: signed addend, used in mode 0.
REQ-011 SHALL have port mode, input, 1 bit: 0 = a*b+c; 1 = a*b+y (accumulate).
REQ-012 SHALL have port clr, input, 1 bit: clears the accumulator (y).
REQ-013 SHALL have port y, output, OUT_WIDTH bits: signed registered result.
REQ-014 SHALL have port out_valid, output, 1 bit: y was updated by a result on the last enabled edge.

Function
REQ-015 SHALL capture a, b, c, mode and in_valid into stage 1 on every edge with en=1, whether in_valid is 1 or 0.
REQ-016 SHALL advance every stage one step per edge with en=1; en=0 SHALL hold every register, including y and out_valid.
REQ-017 SHALL present the result for an operand set on y with out_valid=1 exactly PIPE_DEPTH enabled edges after capture.
REQ-018 SHALL compute the full-precision signed product (2*WIDTH bits) and sign-extend the addend to 2*WIDTH+1 bits before summing.
REQ-019 SHALL form the final sum in the last stage: mode 0 uses the pipelined c; mode 1 uses the current y, sign-extended.
REQ-020 SHALL, when a result exits with in_valid=0 (a bubble), leave y unchanged and drive out_valid=0 for that cycle.
REQ-021 SHALL, on an enabled edge with clr=1 and no exiting valid result, load y with 0 and drive out_valid=0.
REQ-022 SHALL, when clr=1 coincides with an exiting valid mode-1 result, use 0 as the accumulator operand, giving y = a*b.
REQ-023 SHALL ignore clr for an exiting valid mode-0 result; y = a*b+c.
REQ-024 SHALL accept back-to-back valid inputs every enabled cycle; a mode-1 result SHALL use the y produced by the immediately preceding result.
REQ-025 SHALL size the reduction of the sum to OUT_WIDTH as set in Configuration.

Reset
REQ-026 SHALL, while reset=0, asynchronously clear all pipeline registers, y and out_valid to 0, independent of clock and en.
REQ-027 SHALL discard in-flight operands when reset asserts mid-operation; no result SHALL appear after reset deasserts until new valid inputs pass PIPE_DEPTH stages.

Configuration
REQ-028 SHALL, with macro DSP_MULADD_SATURATE_EN defined, clamp the sum to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] before it is loaded into y.
REQ-029 SHALL, without DSP_MULADD_SATURATE_EN, load y with the low OUT_WIDTH bits of the sum (two's-complement wrap).

Verification
REQ-030 SHALL cover defaults, mode 0, a=127, b=1, c=-50, in_valid=1 held -> y=77, out_valid=1 from 3rd enabled edge onward.
REQ-031 SHALL cover mode 0, a=127, b=127, c=0 -> y=1 (wrap) without the macro; y=127 with DSP_MULADD_SATURATE_EN.
REQ-032 SHALL cover clr=1 one cycle, then mode 1, a=3, b=-2 valid for 4 consecutive cycles -> y = -6, -12, -18, -24 on consecutive cycles.
REQ-033 SHALL cover en=0 for 5 cycles mid-stream -> y and out_valid frozen; the sequence resumes unchanged on the next enabled edge.
REQ-034 SHALL cover a valid input, a bubble, then a valid input -> out_valid pattern 1,0,1 with y held during the bubble.
REQ-035 SHALL cover reset=0 asserted with 2 results in flight -> y=0 and out_valid=0 immediately; neither result appears after release.
